// File: rtl/tx_frame_serializer_pkg.sv
// Shared types and line-level constants for the frame serializer.
package tx_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/tx_frame_serializer_if.sv
// Requester-side handshake plus line/status outputs of the serializer.
interface tx_frame_serializer_if #(parameter int N = 5);
  logic [N-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         serial_out;
  logic         busy;
  logic         done;

  modport master (output tx_data, tx_valid, input tx_ready, serial_out, busy, done);
  modport slave  (input tx_data, tx_valid, output tx_ready, serial_out, busy, done);
endinterface

// File: rtl/tx_frame_serializer_shreg.sv
// Parallel-load, right-shifting (zero fill) register exposing bit 0.
module shift_reg_load_n #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] din,
  input  logic         shift_en,
  output logic         bit0
);
  logic [N-1:0] shreg;

  always_ff @(posedge clk) begin
    if (rst)           shreg <= '0;
    else if (load)     shreg <= din;
    else if (shift_en) shreg <= shreg >> 1;
  end

  assign bit0 = shreg[0];
endmodule

// File: rtl/tx_frame_serializer.sv
// Start / N data bits LSB-first / stop framing, CLKS_PER_BIT cycles per bit.
module tx_frame_serializer
  import tx_pkg::*;
#(
  parameter int N            = 5,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  tx_frame_serializer_if.slave bus
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(N + 1);

  tx_state_t       state, state_n;
  logic [BW-1:0]   baud_cnt;
  logic [CW-1:0]   bit_cnt;
  logic            baud_end, accept, load, shift_en, bit0, line_n;

  assign baud_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign accept   = bus.tx_valid & bus.tx_ready;

  shift_reg_load_n #(.N(N)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .din      (bus.tx_data),
    .shift_en (shift_en),
    .bit0     (bit0)
  );

  // The line register is loaded one bit period ahead: each shift happens as the
  // current bit is committed to serial_out, so bit0 already holds the next bit.
  always_comb begin
    state_n  = state;
    load     = 1'b0;
    shift_en = 1'b0;
    line_n   = bus.serial_out;
    unique case (state)
      IDLE: if (accept) begin
        state_n = START;
        load    = 1'b1;
        line_n  = START_BIT;
      end
      START: if (baud_end) begin
        state_n  = DATA;
        shift_en = 1'b1;
        line_n   = bit0;
      end
      DATA: if (baud_end) begin
        if (bit_cnt == CW'(N - 1)) begin
          state_n = STOP;
          line_n  = STOP_BIT;
        end else begin
          shift_en = 1'b1;
          line_n   = bit0;
        end
      end
      STOP: if (baud_end) begin
        state_n = IDLE;
        line_n  = LINE_IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      baud_cnt       <= '0;
      bit_cnt        <= '0;
      bus.serial_out <= LINE_IDLE;
      bus.tx_ready   <= 1'b1;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      state          <= state_n;
      bus.serial_out <= line_n;
      bus.tx_ready   <= (state_n == IDLE);
      bus.busy       <= (state_n != IDLE);
      bus.done       <= (state == STOP) && (state_n == IDLE);
      if (load) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state != IDLE) begin
        baud_cnt <= baud_end ? '0 : baud_cnt + BW'(1);
        if (state == DATA && baud_end) bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end
endmodule

// File: doc/tx_frame_serializer.md
# tx_frame_serializer

Parallel-to-serial transmitter that drives the serial line consumed by the rx_device receive path. It accepts an N-bit word through a valid/ready handshake and frames it as one start bit, N data bits LSB-first, and one stop bit. Each bit is held for CLKS_PER_BIT clock cycles. Data bit order matches the receiver's right-shifting capture, so a word sent here lands in the receiver's shift register unchanged.

## Interface
- N, default 5: data word width; legal range N ≥ 1.
- CLKS_PER_BIT, default 1: clock cycles per serial bit; legal range ≥ 1.

- clk  in  1  rising-edge clock for all state.
- rst  in  1  reset; synchronous and active-high. Sampled only on the rising edge of clk.
- tx_data  in  N  word to send; captured only on the accept edge.
- tx_valid  in  1  requester has a word.
- tx_ready  out  1  block can accept; high only in IDLE.
- serial_out  out  1  registered line output; idles high.
- busy  out  1  high in START, DATA and STOP.
- done  out  1  single-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: serial_out=1, tx_ready=1.
  - Accept when tx_valid & tx_ready at a clock edge. On that edge: load tx_data into the shift register, clear baud_cnt and bit_cnt, go to START.
  - START: serial_out=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: serial_out=shreg[0]. On every bit-period end, shift right (zero fill) and increment bit_cnt. After the N-th bit period, go to STOP.
  - STOP: serial_out=1 for CLKS_PER_BIT cycles, then go to IDLE with done=1 for exactly that first IDLE cycle.
- tx_valid while busy is ignored; it is not queued. tx_data changes after the accept edge have no effect on the frame in flight.
- The requester may hold tx_valid high continuously. Consecutive frames are then separated by exactly one IDLE cycle, during which serial_out=1.
- Counter widths:
  - baud_cnt: max(1, $clog2(CLKS_PER_BIT)) bits.
  - bit_cnt: $clog2(N+1) bits.
  - A bit period ends when baud_cnt == CLKS_PER_BIT-1. baud_cnt wraps to 0 there.
  - When CLKS_PER_BIT=1, every cycle ends a bit period.
- Reset values: state=IDLE, serial_out=1, tx_ready=1, busy=0, done=0, shreg=0, baud_cnt=0, bit_cnt=0.
- Reset mid-frame aborts the frame. Outputs take their reset values on the next edge, and no done pulse is produced.
- Reset and tx_valid on the same edge: reset wins and the word is not accepted.

## Timing
- Edge k = accept edge. serial_out, busy and tx_ready change at edge k, so they are visible in the cycle after k.
- Line segments:
  - Start bit occupies cycles k+1 … k+CLKS_PER_BIT.
  - Data bit i occupies CLKS_PER_BIT cycles starting at cycle k+1+(i+1)·CLKS_PER_BIT.
  - Stop bit ends at cycle k+(N+2)·CLKS_PER_BIT.
- done is high in cycle k+(N+2)·CLKS_PER_BIT+1, with tx_ready=1 in the same cycle.
- Accept-to-accept minimum: (N+2)·CLKS_PER_BIT+1 cycles.
- Outputs are driven directly from registers; there is no combinational path from input to output.

## Structure
- Shared package tx_pkg holds:
  - the state typedef (tx_state_t: IDLE, START, DATA, STOP);
  - the line-level constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
- One sub-module: shift_reg_load_n #(N). It provides:
  - synchronous load of a parallel word;
  - right shift on shift_en with zero fill;
  - a bit-0 output;
  - the same synchronous active-high reset on clk/rst.
- The top level holds the FSM and both counters.

## Test plan
- N=5, CLKS_PER_BIT=1, tx_data=5'b10110: serial_out over cycles k+1…k+7 = 0,0,1,1,0,1,1. done high at cycle k+8.
- N=5, CLKS_PER_BIT=4, tx_data=5'b00001: start low for 4 cycles, then data bit 0 high for 4 cycles, then 16 low cycles, then stop high for 4 cycles. done at cycle k+29.
- tx_valid held high with words 5'h15 then 5'h0A: second accept exactly 8 cycles after the first. One IDLE cycle with serial_out=1 between frames.
- tx_valid pulsed while busy (e.g. at cycle k+3), tx_data changed mid-frame: frame bits unchanged, no extra frame sent.
- rst asserted at cycle k+4 of a CLKS_PER_BIT=1 frame: next edge gives serial_out=1, tx_ready=1, busy=0. done stays 0 for the rest of the test.
- rst high simultaneously with tx_valid: no accept. serial_out stays 1 and no start bit appears.
